// File: rtl/csr_pkg.sv
// csr_pkg: mcause codes, interrupt code mapping and trap FSM states
package csr_pkg;
  localparam int CAUSE_ILLEGAL = 2;
  localparam int CAUSE_LOAD_MISAL = 4;
  localparam int CAUSE_STORE_MISAL = 6;
  localparam int CAUSE_MSI = 3;
  localparam int CAUSE_MTI = 7;
  localparam int CAUSE_MEI = 11;
  typedef enum logic [1:0] {ST_IDLE, ST_TRAP, ST_HOLD} trap_state_e;
  function automatic int irq_code_f(input int ch);
    return ch == 0 ? CAUSE_MSI : ch == 1 ? CAUSE_MTI : ch == 2 ? CAUSE_MEI : 16 + ch - 3;
  endfunction
endpackage

// File: rtl/trap_ctrl_irq_latch.sv
// irq_latch: one interrupt channel pending bit, level-following or rising-edge latched
module irq_latch #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic clr,
  output logic pend
);
  logic irq_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
      pend <= 1'b0;
    end else begin
      irq_q <= irq;
      pend <= EDGE ? (irq & ~irq_q) | (pend & ~clr) : irq;
    end
  end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: M-stage trap/interrupt arbitration with registered trap pulse and re-entry holdoff
module trap_ctrl
  import csr_pkg::*;
#(
  parameter int NUM_IRQS = 3,
  parameter logic [NUM_IRQS-1:0] IRQ_EDGE_MASK = '0,
  parameter int CAUSE_W = 5,
  parameter int IRQ_HOLDOFF = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stallE_i,
  input  logic                flushE_i,
  input  logic                stallM_i,
  input  logic                flushM_i,
  input  logic                illegal_instrD_i,
  input  logic [31:0]         instrD_i,
  input  logic                instr_validM_i,
  input  logic [CAUSE_W-1:0]  sys_excM_i,
  input  logic [1:0]          lsu_misalignedM_i,
  input  logic [31:0]         lsu_addrM_i,
  input  logic [31:0]         pcM_i,
  input  logic                mret_i,
  input  logic [NUM_IRQS-1:0] irq_i,
  input  logic [NUM_IRQS-1:0] irq_clear_i,
  input  logic [NUM_IRQS-1:0] mie_i,
  input  logic                mstatus_mie_i,
  output logic [NUM_IRQS-1:0] irq_pending_o,
  output logic                trap_o,
  output logic                trap_irq_o,
  output logic [CAUSE_W-1:0]  trap_code_o,
  output logic [31:0]         trap_epc_o,
  output logic [31:0]         trap_tval_o
);
  localparam int HW = IRQ_HOLDOFF > 1 ? $clog2(IRQ_HOLDOFF + 1) : 1;
  logic ill_e, ill_m;
  logic [31:0] instr_e, instr_m;
  trap_state_e state, state_n;
  logic [HW-1:0] hold, hold_n;
  logic [NUM_IRQS-1:0] elig;
  logic irq_ok, sync_ev, irq_ev, trap_ev;
  logic [CAUSE_W-1:0] sync_code, irq_code;
  logic [31:0] sync_tval;
  always_ff @(posedge clk_i) begin
    if (rst_i || flushE_i) begin
      ill_e <= 1'b0;
      instr_e <= '0;
    end else if (!stallE_i) begin
      ill_e <= illegal_instrD_i;
      instr_e <= instrD_i;
    end
    if (rst_i || flushM_i) begin
      ill_m <= 1'b0;
      instr_m <= '0;
    end else if (!stallM_i) begin
      ill_m <= ill_e;
      instr_m <= instr_e;
    end
  end
  for (genvar g = 0; g < NUM_IRQS; g++) begin : g_irq
    irq_latch #(.EDGE(IRQ_EDGE_MASK[g])) u_latch (
      .clk(clk_i),
      .rst(rst_i),
      .irq(irq_i[g]),
      .clr(irq_clear_i[g]),
      .pend(irq_pending_o[g])
    );
  end
  assign irq_ok = state == ST_IDLE && hold == '0 && !mret_i;
  assign elig = irq_pending_o & mie_i & {NUM_IRQS{mstatus_mie_i & instr_validM_i & ~stallM_i & irq_ok}};
  assign sync_ev = !stallM_i && !flushM_i && (ill_m || sys_excM_i != '0 || lsu_misalignedM_i != '0);
  assign irq_ev = !flushM_i && elig != '0;
  assign trap_ev = sync_ev || irq_ev;
  assign sync_code = ill_m ? CAUSE_W'(CAUSE_ILLEGAL) : sys_excM_i != '0 ? sys_excM_i :
                     lsu_misalignedM_i[0] ? CAUSE_W'(CAUSE_LOAD_MISAL) : CAUSE_W'(CAUSE_STORE_MISAL);
  assign sync_tval = ill_m ? instr_m : sys_excM_i != '0 ? '0 : lsu_addrM_i;
  always_comb begin
    irq_code = '0;
    for (int i = 3; i < NUM_IRQS; i++) if (elig[i]) irq_code = CAUSE_W'(irq_code_f(i));
    if (elig[1]) irq_code = CAUSE_W'(CAUSE_MTI);
    if (elig[0]) irq_code = CAUSE_W'(CAUSE_MSI);
    if (elig[2]) irq_code = CAUSE_W'(CAUSE_MEI);
  end
  always_comb begin
    hold_n = (trap_ev || mret_i) ? HW'(IRQ_HOLDOFF) : hold != '0 ? hold - HW'(1) : '0;
    state_n = trap_ev ? ST_TRAP : (mret_i && IRQ_HOLDOFF > 0) ? ST_HOLD :
              (state != ST_IDLE && hold > HW'(1)) ? ST_HOLD : ST_IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      hold <= '0;
      trap_o <= 1'b0;
      trap_irq_o <= 1'b0;
      trap_code_o <= '0;
      trap_epc_o <= '0;
      trap_tval_o <= '0;
    end else begin
      state <= state_n;
      hold <= hold_n;
      trap_o <= trap_ev;
      if (trap_ev) begin
        trap_irq_o <= !sync_ev;
        trap_code_o <= sync_ev ? sync_code : irq_code;
        trap_epc_o <= pcM_i;
        trap_tval_o <= sync_ev ? sync_tval : '0;
      end
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed-vector self-checking bench for trap_ctrl
module tb_trap_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic stall_e, flush_e, stall_m, flush_m, ill_d, instr_valid, mret, mstatus_mie;
  logic [31:0] instr_d, lsu_addr, pc;
  logic [4:0] sys_exc, irq, irq_clear, mie, pending, code;
  logic [1:0] misal;
  logic trap, trap_irq;
  logic [31:0] epc, tval;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  trap_ctrl #(.NUM_IRQS(5), .IRQ_EDGE_MASK(5'b10000), .CAUSE_W(5), .IRQ_HOLDOFF(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .stallE_i(stall_e),
    .flushE_i(flush_e),
    .stallM_i(stall_m),
    .flushM_i(flush_m),
    .illegal_instrD_i(ill_d),
    .instrD_i(instr_d),
    .instr_validM_i(instr_valid),
    .sys_excM_i(sys_exc),
    .lsu_misalignedM_i(misal),
    .lsu_addrM_i(lsu_addr),
    .pcM_i(pc),
    .mret_i(mret),
    .irq_i(irq),
    .irq_clear_i(irq_clear),
    .mie_i(mie),
    .mstatus_mie_i(mstatus_mie),
    .irq_pending_o(pending),
    .trap_o(trap),
    .trap_irq_o(trap_irq),
    .trap_code_o(code),
    .trap_epc_o(epc),
    .trap_tval_o(tval)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clear_in();
    {stall_e, flush_e, stall_m, flush_m, ill_d, instr_valid, mret, mstatus_mie} = '0;
    {instr_d, lsu_addr, sys_exc, irq, irq_clear, mie, misal} = '0;
    pc = 32'h100;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    check("rst_trap", trap, 0);
    check("rst_code", code, 0);
    check("rst_epc", epc, 0);
    check("rst_pend", pending, 0);
    ill_d = 1;
    instr_d = 32'hFFFF_FFFF;
    tick();
    ill_d = 0;
    tick();
    check("ill_early", trap, 0);
    tick();
    check("ill_trap", trap, 1);
    check("ill_code", code, 2);
    check("ill_irq", trap_irq, 0);
    check("ill_tval", tval, 32'hFFFF_FFFF);
    check("ill_epc", epc, 32'h100);
    tick();
    check("ill_pulse", trap, 0);
    check("ill_hold_code", code, 2);
    do_reset();
    ill_d = 1;
    flush_e = 1;
    tick();
    ill_d = 0;
    flush_e = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flushE_none", trap, 0);
    end
    instr_d = 32'hDEAD_BEEF;
    ill_d = 1;
    tick();
    ill_d = 0;
    tick();
    stall_m = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stallM_none", trap, 0);
    end
    stall_m = 0;
    tick();
    check("stallM_trap", trap, 1);
    check("stallM_tval", tval, 32'hDEAD_BEEF);
    tick();
    check("stallM_pulse", trap, 0);
    do_reset();
    sys_exc = 5'd11;
    misal = 2'b10;
    lsu_addr = 32'h2002;
    tick();
    check("ecall_code", code, 11);
    check("ecall_tval", tval, 0);
    sys_exc = 0;
    pc = 32'h300;
    tick();
    check("st_code", code, 6);
    check("st_tval", tval, 32'h2002);
    check("st_epc", epc, 32'h300);
    misal = 0;
    tick();
    flush_m = 1;
    sys_exc = 5'd3;
    tick();
    check("flushM_none", trap, 0);
    flush_m = 0;
    sys_exc = 0;
    do_reset();
    irq[2] = 1;
    tick();
    check("mei_pend", pending, 5'b00100);
    mie = 5'b00100;
    mstatus_mie = 1;
    instr_valid = 1;
    misal = 2'b01;
    lsu_addr = 32'h1003;
    pc = 32'h200;
    tick();
    check("misal_trap", trap, 1);
    check("misal_code", code, 4);
    check("misal_irq", trap_irq, 0);
    check("misal_tval", tval, 32'h1003);
    misal = 0;
    tick();
    check("hold_a", trap, 0);
    tick();
    check("hold_b", trap, 0);
    tick();
    check("mei_trap", trap, 1);
    check("mei_irq", trap_irq, 1);
    check("mei_code", code, 11);
    check("mei_tval", tval, 0);
    do_reset();
    mie = 5'b10000;
    mstatus_mie = 1;
    instr_valid = 1;
    irq[4] = 1;
    tick();
    irq[4] = 0;
    check("edge_pend", pending, 5'b10000);
    tick();
    check("edge_trap", trap, 1);
    check("edge_irq", trap_irq, 1);
    check("edge_code", code, 17);
    check("edge_sticky", pending, 5'b10000);
    irq_clear[4] = 1;
    tick();
    check("edge_clr", pending, 0);
    mie = 0;
    irq[4] = 1;
    tick();
    irq[4] = 0;
    irq_clear[4] = 0;
    check("edge_set_wins", pending, 5'b10000);
    do_reset();
    irq = 5'b00011;
    mie = 5'b00011;
    mstatus_mie = 1;
    instr_valid = 1;
    tick();
    check("msi_mti_pend", pending, 5'b00011);
    tick();
    check("msi_trap", trap, 1);
    check("msi_code", code, 3);
    mstatus_mie = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mie0_none", trap, 0);
    end
    check("mie0_pend", pending, 5'b00011);
    do_reset();
    irq[1] = 1;
    mie = 5'b00010;
    mstatus_mie = 1;
    tick();
    mret = 1;
    instr_valid = 1;
    tick();
    mret = 0;
    check("mret_none", trap, 0);
    tick();
    check("hold_1", trap, 0);
    tick();
    check("hold_2", trap, 0);
    tick();
    check("mti_trap", trap, 1);
    check("mti_code", code, 7);
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("rst_hold_trap", trap, 0);
    check("rst_hold_code", code, 0);
    check("rst_hold_epc", epc, 0);
    check("rst_hold_pend", pending, 0);
    tick();
    tick();
    check("post_rst_trap", trap, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
